// File: rtl/alu_serial_seq.sv
// -----------------------------------------------------------------------------
// alu_serial_seq
//   Bit-serial ALU sequencer. A WIDTH-bit operand pair is pushed LSB-first
//   through a single 1-bit ALU slice (AND / OR / full-add), one bit per clock.
//   SUB is executed as A + ~B + 1 on the same adder slice.
//
//   Handshakes:
//     request side  : valid_i / ready_o   (accepted only in IDLE)
//     response side : valid_o / ready_i   (result held in DONE until taken)
//
//   Optional build macro:
//     ALU_SERIAL_OVF_EN - when defined, ovf_o reports signed overflow for
//                         ADD/SUB (carry into MSB XOR carry out of MSB).
//                         When undefined, ovf_o is tied to 0 and the overflow
//                         flip-flop does not exist. Ports are identical.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// alu_bit_slice
//   One-bit ALU slice. Op encodings: 00 AND, 01 OR, 10 full add.
//   Carry out is only meaningful for the full-add op; it is 0 otherwise.
// -----------------------------------------------------------------------------
module alu_bit_slice (
    input  logic [1:0] i_op,
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c,
    output logic       o_r,
    output logic       o_c
);

    // Pure combinational bit operation selected by the slice op code.
    always_comb begin
        // NOTE: every output gets a default before the case so that an
        // unlisted op code cannot leave a path unassigned and infer a latch.
        o_r = 1'b0;
        o_c = 1'b0;
        case (i_op)
            2'b00: o_r = i_a & i_b;
            2'b01: o_r = i_a | i_b;
            2'b10: begin
                o_r = i_a ^ i_b ^ i_c;
                o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
            end
            default: begin
                o_r = 1'b0;
                o_c = 1'b0;
            end
        endcase
    end

endmodule

// -----------------------------------------------------------------------------
// alu_serial_seq (top)
// -----------------------------------------------------------------------------
module alu_serial_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    input  logic             abort_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             ovf_o
);

    // Request op codes as seen on op_i.
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // Counter value during the cycle that processes the MSB.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // ---------------------------------------------------------------- state
    state_t             r_state;
    state_t             w_state_nxt;

    // ------------------------------------------------------------ datapath
    logic [WIDTH-1:0]   r_a;        // operand A, shifted right each RUN cycle
    logic [WIDTH-1:0]   r_b;        // operand B (or ~B for SUB), shifted right
    logic [WIDTH-1:0]   r_res;      // result assembled MSB-in, shifted right
    logic [1:0]         r_op;       // latched request op
    logic               r_carry;    // carry between consecutive bit positions
    logic [CNT_W-1:0]   r_cnt;      // index of the bit being processed

    // ------------------------------------------------------ output registers
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_zero;

    // ------------------------------------------------------------ wires
    logic               w_accept;     // request handshake in IDLE
    logic               w_step;       // a bit is processed this cycle
    logic               w_last;       // MSB is processed this cycle, no abort
    logic               w_is_arith;   // latched op is ADD or SUB
    logic [1:0]         w_slice_op;   // op code presented to the slice
    logic               w_bit;        // slice result bit
    logic               w_cout;       // slice carry out
    logic [WIDTH-1:0]   w_res_final;  // full result including the MSB bit

    assign w_accept    = (r_state == S_IDLE) && valid_i;
    assign w_step      = (r_state == S_RUN) && !abort_i;
    assign w_last      = w_step && (r_cnt == LAST_CNT);
    assign w_is_arith  = r_op[1];
    // ADD and SUB both run on the slice's full-add op.
    assign w_slice_op  = w_is_arith ? 2'b10 : r_op;
    assign w_res_final = {w_bit, r_res[WIDTH-1:1]};

    alu_bit_slice u_slice (
        .i_op (w_slice_op),
        .i_a  (r_a[0]),
        .i_b  (r_b[0]),
        .i_c  (r_carry),
        .o_r  (w_bit),
        .o_c  (w_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every register samples pre-edge values regardless of order.
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort in RUN has priority over finishing the MSB.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (valid_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register.
    assign ready_o = (r_state == S_IDLE);
    assign valid_o = (r_state == S_DONE);

    // Operand capture on accept, then one LSB-first shift step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath is cleared on reset so that the carry and
            // counter start from known values and never propagate X.
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_op    <= OP_AND;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a_i;
            // SUB is A + ~B + 1: invert B here and preset the carry to 1.
            r_b     <= (op_i == OP_SUB) ? ~b_i : b_i;
            r_op    <= op_i;
            r_carry <= (op_i == OP_SUB);
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= w_res_final;
            // Logical ops keep the carry at 0 so the slice sees a clean input.
            r_carry <= w_is_arith ? w_cout : 1'b0;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Result, carry and zero flags update only when an operation completes,
    // so they hold their previous values through IDLE, RUN and aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_last) begin
            r_result    <= w_res_final;
            r_carry_out <= w_is_arith & w_cout;
            r_zero      <= (w_res_final == '0);
        end
    end

    assign result_o = r_result;
    assign carry_o  = r_carry_out;
    assign zero_o   = r_zero;

`ifdef ALU_SERIAL_OVF_EN
    logic r_ovf;

    // During the MSB cycle r_carry still holds the carry into the MSB, so
    // overflow is that value XOR the slice's carry out of the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_is_arith & (r_carry ^ w_cout);
        end
    end

    assign ovf_o = r_ovf;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_seq
//   Scoreboard bench for alu_serial_seq at WIDTH=8. The driver pushes the
//   expected response of every request that is meant to complete; a separate
//   monitor pops and compares whenever valid_o is high, and keeps comparing
//   the held response on every backpressured cycle. Define ALU_SERIAL_OVF_EN
//   for both bench and RTL to exercise the overflow flag.
// -----------------------------------------------------------------------------
module tb_alu_serial_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [1:0]       op_i;
    logic             abort_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic             carry_o;
    logic             zero_o;
    logic             ovf_o;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .op_i     (op_i),
        .abort_i  (abort_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .carry_o  (carry_o),
        .zero_o   (zero_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             z;
        logic             v;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: plain integer arithmetic on the whole word.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [1:0] op);
        exp_t e;
        int   ua = int'(a);
        int   ub = int'(b);
        int   sa = ua - (a[WIDTH-1] ? (1 << WIDTH) : 0);
        int   sb = ub - (b[WIDTH-1] ? (1 << WIDTH) : 0);
        int   r;
        int   sr;
        e.c = 1'b0;
        e.v = 1'b0;
        case (op)
            2'b00: r = ua & ub;
            2'b01: r = ua | ub;
            2'b10: begin
                r   = ua + ub;
                e.c = (r >= (1 << WIDTH));
                sr  = sa + sb;
                e.v = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
            end
            default: begin
                r   = ua - ub + (1 << WIDTH);
                e.c = (ua >= ub);
                sr  = sa - sb;
                e.v = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
            end
        endcase
        e.res = WIDTH'(r);
        e.z   = (e.res == '0);
`ifndef ALU_SERIAL_OVF_EN
        e.v = 1'b0;
`endif
        return e;
    endfunction

    // Monitor: compare every cycle valid_o is high; a response retires once
    // it is presented together with ready_i.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_cur = 1'b0;
            end else if (valid_o) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid_o", valid_o, 1'b0);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    check("result_o", result_o, cur.res);
                    check("carry_o",  carry_o,  cur.c);
                    check("zero_o",   zero_o,   cur.z);
                    check("ovf_o",    ovf_o,    cur.v);
                    if (ready_i) have_cur = 1'b0;
                end
            end
        end
    end

    // Issue one request. abort_cyc>0 aborts during that RUN cycle (1-based);
    // hold is the number of DONE cycles with ready_i low.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] op, input int abort_cyc, input int hold);
        int n;
        int edges;
        @(posedge clk); #1;
        n = 0;
        while (!ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", ready_o, 1'b1);
        a_i     = a;
        b_i     = b;
        op_i    = op;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        // Operands must only be sampled at acceptance.
        a_i  = WIDTH'($urandom);
        b_i  = WIDTH'($urandom);
        op_i = 2'($urandom);
        if (abort_cyc > 0) begin
            repeat (abort_cyc - 1) begin
                @(posedge clk); #1;
            end
            abort_i = 1'b1;
            @(posedge clk); #1;
            abort_i = 1'b0;
            check("abort_ready_o", ready_o, 1'b1);
            check("abort_valid_o", valid_o, 1'b0);
        end else begin
            exp_q.push_back(model(a, b, op));
            // The accept edge counts as edge 1.
            edges = 1;
            while (!valid_o && edges < WIDTH + 20) begin
                @(posedge clk); #1;
                edges++;
            end
            check("latency_edges", edges, WIDTH + 1);
            for (int i = 0; i < hold; i++) begin
                valid_i = 1'($urandom);
                @(posedge clk); #1;
                check("hold_valid_o", valid_o, 1'b1);
                check("hold_ready_o", ready_o, 1'b0);
            end
            valid_i = 1'b0;
            ready_i = 1'b1;
            @(posedge clk); #1;
            ready_i = 1'b0;
            check("release_ready_o", ready_o, 1'b1);
            check("release_valid_o", valid_o, 1'b0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        abort_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        op_i    = 2'b00;
        #2;
        check("rst_ready_o",  ready_o,  1'b1);
        check("rst_valid_o",  valid_o,  1'b0);
        check("rst_result_o", result_o, '0);
        check("rst_carry_o",  carry_o,  1'b0);
        check("rst_zero_o",   zero_o,   1'b0);
        check("rst_ovf_o",    ovf_o,    1'b0);
        #10 rst_n = 1'b1;

        // Directed cases.
        run_op(8'h7F, 8'h01, 2'b10, 0, 0);
        run_op(8'h05, 8'h05, 2'b11, 0, 1);
        run_op(8'h03, 8'h05, 2'b11, 0, 0);
        run_op(8'hF0, 8'h3C, 2'b00, 0, 2);
        run_op(8'hF0, 8'h3C, 2'b01, 0, 0);
        run_op(8'h80, 8'h01, 2'b11, 0, 5);
        run_op(8'h12, 8'h34, 2'b10, 3, 0);
        run_op(8'hFF, 8'h01, 2'b10, 0, 0);
        // Abort coinciding with the MSB cycle must win.
        run_op(8'hAA, 8'h55, 2'b01, WIDTH, 0);

        // Asynchronous reset in RUN cycle 4, between clock edges.
        @(posedge clk); #1;
        a_i     = 8'h11;
        b_i     = 8'h22;
        op_i    = 2'b10;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_ready_o",  ready_o,  1'b1);
        check("midrun_rst_valid_o",  valid_o,  1'b0);
        check("midrun_rst_result_o", result_o, '0);
        check("midrun_rst_carry_o",  carry_o,  1'b0);
        check("midrun_rst_zero_o",   zero_o,   1'b0);
        check("midrun_rst_ovf_o",    ovf_o,    1'b0);
        #2 rst_n = 1'b1;
        run_op(8'h40, 8'h40, 2'b10, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic [1:0]       rop;
            int               ab;
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            rop = 2'($urandom);
            ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, WIDTH)) : 0;
            run_op(ra, rb, rop, ab, int'($urandom_range(0, 3)));
        end

        begin
            int n = 0;
            while ((exp_q.size() != 0 || have_cur) && n < 100) begin
                @(posedge clk);
                n++;
            end
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
